store_writer: RTL and testbench
===============================

Name: store_writer

Overview:
- Store-side counterpart of the writeback load-data extractor. That extractor selects and sign-extends bytes from a 64-bit read word; this block does the opposite for stores.
- It takes a store (address, raw rs2 data, msize) from the memory stage. It checks alignment, replicates the data into byte lanes and generates the byte strobe.
- It drives one data-bus write transaction with a valid/data_ok handshake and reports completion or a misaligned-store fault to the pipeline.

Parameters:
- ADDR_W, 64, width of the store address.
- DATA_W, 64, bus data width. Fixed at 64; the strobe width is DATA_W/8.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  store request from the memory stage.
- in_ready  out  1  block can accept a request this cycle.
- in_addr  in  64  store address.
- in_data  in  64  raw rs2 value; the low bytes are significant.
- in_msize  in  2  msize_t: MSIZE1, MSIZE2, MSIZE4 or MSIZE8.
- flush  in  1  pipeline flush; squashes this block's reported result.
- dreq_valid  out  1  bus write request.
- dreq_addr  out  64  bus address, equal to in_addr as accepted.
- dreq_size  out  2  msize_t of the access.
- dreq_strobe  out  8  byte-lane write enable.
- dreq_data  out  64  lane-replicated write data.
- dresp_data_ok  in  1  bus write completed.
- out_done  out  1  one-cycle pulse: store committed.
- out_misalign  out  1  one-cycle pulse: store address misaligned.
- out_badaddr  out  64  faulting address; valid while out_misalign is high.

Behaviour:
- Reset is asynchronous, active-low. While resetn is low:
  - state goes to IDLE.
  - dreq_valid, out_done, out_misalign and the kill flag are 0.
  - dreq_addr, dreq_data, dreq_strobe, dreq_size and out_badaddr are 0.
  - A reset during an outstanding request drops dreq_valid immediately; the bus must tolerate this.
- States: IDLE, REQ, DONE, FAULT.
- in_ready = (state==IDLE) && !flush.
- A request is accepted when in_valid && in_ready. All request fields are registered at acceptance; the outputs are driven from registers only.
- Alignment at accept:
  - MSIZE1 is always aligned.
  - MSIZE2 faults if addr[0] is set.
  - MSIZE4 faults if addr[1:0] is nonzero.
  - MSIZE8 faults if addr[2:0] is nonzero.
- Data replication, with off = addr[2:0]:
  - MSIZE1: data becomes 8 copies of in_data[7:0]; strobe = 8'b0000_0001 << off.
  - MSIZE2: 4 copies of in_data[15:0]; strobe = 8'b0000_0011 << off.
  - MSIZE4: 2 copies of in_data[31:0]; strobe = 8'b0000_1111 << off.
  - MSIZE8: in_data unchanged; strobe = 8'hFF.
- Aligned accept moves to REQ. dreq_valid = 1 from the next cycle. Address, size, strobe and data stay constant while in REQ.
- In REQ with dresp_data_ok = 1: dreq_valid drops the next cycle and state moves to DONE. Latency from accept to out_done is 2 + (bus wait) cycles; the minimum is 2 cycles when ok arrives in the first REQ cycle.
- DONE lasts one cycle: out_done = !kill, then IDLE. Back-to-back stores are accepted starting in the IDLE cycle after DONE.
- Misaligned accept moves to FAULT with no bus request.
  - FAULT lasts one cycle: out_misalign = !kill and out_badaddr = the accepted address, then IDLE.
- Flush:
  - In REQ, flush sets kill. The bus transaction still runs to data_ok because the bus cannot abort; the out_done pulse is suppressed.
  - A flush asserted in the DONE or FAULT cycle suppresses that cycle's pulse combinationally.
  - In IDLE, flush blocks acceptance via in_ready.
  - kill clears on entry to IDLE.
- dresp_data_ok outside REQ is ignored.
- An unknown msize is treated as a fault: FAULT state with out_misalign.

Decomposition:
- msize_t and the MSIZE* encodings are reused from decode_pkg.
- Add to pipes:
  - a store_state_t enum for IDLE/REQ/DONE/FAULT.
  - a store_req_t struct {addr, data, msize}.
- Natural sub-module: store_format. It is purely combinational: in (addr[2:0], data, msize) -> (strobe, lane data, misalign). The FSM instantiates it at the accept point.

Test Plan:
- SB addr 0x1003, data 0x..AB, ok in the first REQ cycle -> dreq_strobe=0x08, dreq_data=0xABABABABABABABAB, out_done exactly 2 cycles after accept.
- SH addr 0x2006, data 0x1234, ok delayed 3 cycles -> dreq_valid held 4 cycles with strobe=0xC0 and data=0x1234123412341234 stable; one out_done pulse.
- SW addr 0x3002 -> dreq_valid never asserts; out_misalign pulses 1 cycle after accept with out_badaddr=0x3002; in_ready returns the next cycle.
- SD addr 0x4000, flush in the second REQ cycle, ok in the third -> transaction completes with strobe=0xFF; out_done stays 0; the next store is accepted normally.
- resetn low during REQ -> dreq_valid goes 0 immediately; after release state is IDLE with in_ready=1; a stray dresp_data_ok causes no pulse.
- Two back-to-back aligned SW stores (0x5000, 0x5004) with immediate ok -> strobes 0x0F then 0xF0; two out_done pulses 3 cycles apart.

Source files
------------

// File: rtl/store_writer_pkg.sv
// store_writer_pkg: shared types for the store path.
//   msize_t        : access size encoding (1/2/4/8 bytes)
//   store_state_t  : store_writer FSM states
//   store_req_t    : one store request {addr, data, msize}
package store_writer_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;          // bus width is fixed at 64
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } store_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    msize_t            msize;
  } store_req_t;

endpackage

// File: rtl/store_writer_if.sv
// store_writer_if: data-bus write channel.
//   dreq_valid/addr/size/strobe/data : write request (master drives)
//   dresp_data_ok                    : write completion (slave drives)
// Modports: master = store block, slave = bus side.
interface store_writer_if;
  import store_writer_pkg::*;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  msize_t            dreq_size;
  logic [STRB_W-1:0] dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_data_ok;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok
  );
endinterface

// File: rtl/store_writer_format.sv
// store_writer_format: combinational store formatter.
//   off       in  3   byte offset within the 64-bit word (addr[2:0])
//   data      in  64  raw rs2 value, low bytes significant
//   msize     in  2   access size
//   strobe    out 8   byte-lane write enable
//   lane_data out 64  data replicated into every lane of its size
//   misalign  out 1   offset not a multiple of the size, or unknown size
module store_writer_format
  import store_writer_pkg::*;
(
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] data,
  input  msize_t            msize,
  output logic [STRB_W-1:0] strobe,
  output logic [DATA_W-1:0] lane_data,
  output logic              misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    strobe    = '0;
    lane_data = '0;
    misalign  = 1'b0;
    case (msize)
      MSIZE1: begin
        strobe    = 8'b0000_0001 << off;
        lane_data = {8{data[7:0]}};
      end
      MSIZE2: begin
        strobe    = 8'b0000_0011 << off;
        lane_data = {4{data[15:0]}};
        misalign  = off[0];
      end
      MSIZE4: begin
        strobe    = 8'b0000_1111 << off;
        lane_data = {2{data[31:0]}};
        misalign  = |off[1:0];
      end
      MSIZE8: begin
        strobe    = 8'hFF;
        lane_data = data;
        misalign  = |off;
      end
      default: misalign = 1'b1;   // unknown size is reported as a fault
    endcase
  end

endmodule

// File: rtl/store_writer.sv
// store_writer: accepts one store from the memory stage, checks alignment,
// formats lanes/strobe and runs a single valid/data_ok bus write.
//   clk, resetn       : clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake from the memory stage
//   in_addr/data/msize: store address, raw rs2 data, size
//   flush             : squashes this block's reported result
//   bus               : data-bus write channel (master side)
//   out_done          : one-cycle pulse, store committed
//   out_misalign      : one-cycle pulse, misaligned store
//   out_badaddr       : faulting address while out_misalign is high
module store_writer
  import store_writer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  msize_t            in_msize,
  input  logic              flush,
  store_writer_if.master    bus,
  output logic              out_done,
  output logic              out_misalign,
  output logic [ADDR_W-1:0] out_badaddr
);

  store_state_t      state;
  logic              kill;
  logic              dreq_valid_q;
  store_req_t        req_q;          // data field holds lane-replicated data
  logic [STRB_W-1:0] strobe_q;

  logic [STRB_W-1:0] fmt_strobe;
  logic [DATA_W-1:0] fmt_data;
  logic              fmt_misalign;
  logic              accept;

  store_writer_format u_format (
    .off       (in_addr[2:0]),
    .data      (in_data),
    .msize     (in_msize),
    .strobe    (fmt_strobe),
    .lane_data (fmt_data),
    .misalign  (fmt_misalign)
  );

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      kill         <= 1'b0;
      dreq_valid_q <= 1'b0;
      req_q        <= '0;
      strobe_q     <= '0;
      out_badaddr  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of its neighbours.
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.addr  <= in_addr;
            req_q.msize <= in_msize;
            if (fmt_misalign) begin
              state       <= FAULT;
              out_badaddr <= in_addr;
            end else begin
              state        <= REQ;
              dreq_valid_q <= 1'b1;
              req_q.data   <= fmt_data;
              strobe_q     <= fmt_strobe;
            end
          end
        end
        REQ: begin
          // The bus cannot abort, so a flush only marks the result as dead.
          if (flush) kill <= 1'b1;
          if (bus.dresp_data_ok) begin
            dreq_valid_q <= 1'b0;
            state        <= DONE;
          end
        end
        default: begin            // DONE, FAULT: single-cycle report states
          state <= IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dreq_valid  = dreq_valid_q;
  assign bus.dreq_addr   = req_q.addr;
  assign bus.dreq_size   = req_q.msize;
  assign bus.dreq_data   = req_q.data;
  assign bus.dreq_strobe = strobe_q;

  // A flush in the report cycle itself must still squash the pulse.
  assign out_done     = (state == DONE)  && !kill && !flush;
  assign out_misalign = (state == FAULT) && !kill && !flush;

endmodule

// File: tb/tb_store_writer.sv
// tb_store_writer: table-driven directed checks plus hand-written sequences
// for flush, reset-during-request and back-to-back stores.
module tb_store_writer;
  import store_writer_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_data;
  msize_t      in_msize;
  logic        flush;
  logic        out_done;
  logic        out_misalign;
  logic [63:0] out_badaddr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  store_writer_if bus_if ();

  store_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_msize     (in_msize),
    .flush        (flush),
    .bus          (bus_if),
    .out_done     (out_done),
    .out_misalign (out_misalign),
    .out_badaddr  (out_badaddr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    msize_t      msize;
    int          wait_n;     // REQ cycles before data_ok
    logic        exp_mis;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one store from accept to return-to-IDLE, checking every cycle.
  task automatic run_vec(input vec_t v, input string tag, output int done_cyc);
    done_cyc = -1;
    in_valid = 1'b1; in_addr = v.addr; in_data = v.data; in_msize = v.msize;
    #1;
    check({tag, " ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_data = '0;
    #1;
    if (v.exp_mis) begin
      check({tag, " no_req"}, bus_if.dreq_valid, 1'b0);
      check({tag, " misalign"}, out_misalign, 1'b1);
      check({tag, " badaddr"}, out_badaddr, v.addr);
      check({tag, " no_done"}, out_done, 1'b0);
      check({tag, " ready_low"}, in_ready, 1'b0);
      step();
      #1;
      check({tag, " misalign_end"}, out_misalign, 1'b0);
    end else begin
      for (int k = 0; k <= v.wait_n; k++) begin
        bus_if.dresp_data_ok = (k == v.wait_n);
        check({tag, " valid"}, bus_if.dreq_valid, 1'b1);
        check({tag, " strobe"}, bus_if.dreq_strobe, v.exp_strb);
        check({tag, " data"}, bus_if.dreq_data, v.exp_data);
        check({tag, " addr"}, bus_if.dreq_addr, v.addr);
        check({tag, " size"}, bus_if.dreq_size, v.msize);
        check({tag, " early_done"}, out_done, 1'b0);
        step();
        bus_if.dresp_data_ok = 1'b0;
        #1;
      end
      check({tag, " valid_drop"}, bus_if.dreq_valid, 1'b0);
      check({tag, " done"}, out_done, 1'b1);
      check({tag, " no_mis"}, out_misalign, 1'b0);
      done_cyc = cyc;
      step();
      #1;
      check({tag, " done_end"}, out_done, 1'b0);
    end
    check({tag, " ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, dc2;
    vec_t v;

    vecs[0] = '{64'h1003, 64'h1122334455667_7AB, MSIZE1, 0, 1'b0, 8'h08, 64'hABAB_ABAB_ABAB_ABAB};
    vecs[1] = '{64'h2006, 64'hFFFF_FFFF_FFFF_1234, MSIZE2, 3, 1'b0, 8'hC0, 64'h1234_1234_1234_1234};
    vecs[2] = '{64'h3002, 64'h0000_0000_1111_2222, MSIZE4, 0, 1'b1, 8'h00, 64'h0};
    vecs[3] = '{64'h0000, 64'h0000_0000_0000_0055, MSIZE1, 1, 1'b0, 8'h01, 64'h5555_5555_5555_5555};
    vecs[4] = '{64'h2001, 64'h0000_0000_0000_BEEF, MSIZE2, 0, 1'b1, 8'h00, 64'h0};
    vecs[5] = '{64'h6008, 64'h0123_4567_89AB_CDEF, MSIZE8, 0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[6] = '{64'h600C, 64'h0123_4567_89AB_CDEF, MSIZE8, 0, 1'b1, 8'h00, 64'h0};
    vecs[7] = '{64'h7004, 64'hDEAD_BEEF_CAFE_F00D, MSIZE4, 2, 1'b0, 8'hF0, 64'hCAFE_F00D_CAFE_F00D};
    vecs[8] = '{64'h7007, 64'h0000_0000_0000_0080, MSIZE1, 0, 1'b0, 8'h80, 64'h8080_8080_8080_8080};
    vecs[9] = '{64'h7000, 64'h1111_2222_3333_BEEF, MSIZE2, 0, 1'b0, 8'h03, 64'hBEEF_BEEF_BEEF_BEEF};

    resetn = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_msize = MSIZE1; flush = 1'b0; bus_if.dresp_data_ok = 1'b0;
    repeat (2) step();
    check("rst dreq_valid", bus_if.dreq_valid, 1'b0);
    check("rst dreq_strobe", bus_if.dreq_strobe, 8'h00);
    check("rst dreq_data", bus_if.dreq_data, 64'h0);
    check("rst out_done", out_done, 1'b0);
    check("rst out_misalign", out_misalign, 1'b0);
    check("rst out_badaddr", out_badaddr, 64'h0);
    check("rst in_ready", in_ready, 1'b1);
    resetn = 1'b1;
    step();

    // Table-driven stores; vector 0 also checks the 2-cycle accept-to-done latency.
    for (int i = 0; i < 10; i++) begin
      int c0;
      c0 = cyc;
      run_vec(vecs[i], $sformatf("vec%0d", i), dc);
      if (i == 0) check("sb latency", dc - c0, 2);
    end

    // Flush in the 2nd REQ cycle of an SD, ok in the 3rd: bus completes, no done.
    in_valid = 1'b1; in_addr = 64'h4000; in_data = 64'hA5A5_5A5A_0F0F_F0F0; in_msize = MSIZE8;
    step();
    in_valid = 1'b0;
    #1 check("fl req1 valid", bus_if.dreq_valid, 1'b1);
    step();
    flush = 1'b1;
    #1 check("fl req2 valid", bus_if.dreq_valid, 1'b1);
    check("fl req2 ready", in_ready, 1'b0);
    step();
    flush = 1'b0; bus_if.dresp_data_ok = 1'b1;
    #1 check("fl req3 strobe", bus_if.dreq_strobe, 8'hFF);
    check("fl req3 data", bus_if.dreq_data, 64'hA5A5_5A5A_0F0F_F0F0);
    step();
    bus_if.dresp_data_ok = 1'b0;
    #1 check("fl done suppressed", out_done, 1'b0);
    check("fl valid drop", bus_if.dreq_valid, 1'b0);
    step();
    #1 check("fl ready back", in_ready, 1'b1);
    v = '{64'h10, 64'h77, MSIZE1, 0, 1'b0, 8'h01, 64'h7777_7777_7777_7777};
    run_vec(v, "after_flush", dc);

    // Flush landing in the DONE cycle, then flush blocking acceptance in IDLE.
    in_valid = 1'b1; in_addr = 64'h18; in_data = 64'h1; in_msize = MSIZE1;
    step();
    in_valid = 1'b0; bus_if.dresp_data_ok = 1'b1;
    step();
    bus_if.dresp_data_ok = 1'b0; flush = 1'b1;
    #1 check("done-cycle flush", out_done, 1'b0);
    step();
    in_valid = 1'b1; in_addr = 64'h20;
    #1 check("idle flush ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0; flush = 1'b0;
    #1 check("idle flush no_req", bus_if.dreq_valid, 1'b0);
    check("idle flush ready back", in_ready, 1'b1);

    // Flush in the FAULT cycle hides the misalign pulse.
    in_valid = 1'b1; in_addr = 64'h21; in_msize = MSIZE4;
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1 check("fault-cycle flush", out_misalign, 1'b0);
    step();
    flush = 1'b0;

    // Reset while in REQ drops dreq_valid at once; stray data_ok is ignored.
    in_valid = 1'b1; in_addr = 64'h8000; in_data = 64'h9; in_msize = MSIZE4;
    step();
    in_valid = 1'b0;
    #1 check("rstreq valid", bus_if.dreq_valid, 1'b1);
    #2 resetn = 1'b0;
    #1 check("rstreq async drop", bus_if.dreq_valid, 1'b0);
    check("rstreq strobe clr", bus_if.dreq_strobe, 8'h00);
    @(negedge clk) resetn = 1'b1;
    step();
    check("rstreq ready", in_ready, 1'b1);
    bus_if.dresp_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stray ok done", out_done, 1'b0);
      check("stray ok valid", bus_if.dreq_valid, 1'b0);
    end
    bus_if.dresp_data_ok = 1'b0;

    // Back-to-back SW stores: strobes 0F then F0, done pulses 3 cycles apart.
    v = '{64'h5000, 64'h0000_0000_AAAA_BBBB, MSIZE4, 0, 1'b0, 8'h0F, 64'hAAAA_BBBB_AAAA_BBBB};
    in_valid = 1'b1; in_addr = v.addr; in_data = v.data; in_msize = v.msize;
    step();
    in_valid = 1'b0; bus_if.dresp_data_ok = 1'b1;
    #1 check("b2b a strobe", bus_if.dreq_strobe, 8'h0F);
    step();
    bus_if.dresp_data_ok = 1'b0;
    #1 check("b2b a done", out_done, 1'b1);
    dc = cyc;
    step();
    in_valid = 1'b1; in_addr = 64'h5004; in_data = 64'h0000_0000_CCCC_DDDD; in_msize = MSIZE4;
    #1 check("b2b b ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; bus_if.dresp_data_ok = 1'b1;
    #1 check("b2b b strobe", bus_if.dreq_strobe, 8'hF0);
    check("b2b b data", bus_if.dreq_data, 64'hCCCC_DDDD_CCCC_DDDD);
    step();
    bus_if.dresp_data_ok = 1'b0;
    #1 check("b2b b done", out_done, 1'b1);
    dc2 = cyc;
    check("b2b spacing", dc2 - dc, 3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
